// File: rtl/matrix_scan_driver.sv
// Column-multiplexed driver for a 5x7 active-low LED matrix with anti-ghost blanking
// and a blinking cursor overlay. Each column's map slice and cursor are latched at the start of its dwell.
module matrix_scan_driver #(
    parameter int DATA_WIDTH    = 35,
    parameter int COLUNE_SIZE   = 7,
    parameter int TOTAL_COLUNES = 5,
    parameter int COL_DWELL     = 1000,
    parameter int BLANK_CYCLES  = 50,
    parameter int BLINK_FRAMES  = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    matriz_data,
    input  logic [2:0]               x_coord_code,
    input  logic [2:0]               y_coord_code,
    input  logic                     cursor_enable,
    output logic [TOTAL_COLUNES-1:0] matrix_col,
    output logic [COLUNE_SIZE-1:0]   matrix_row,
    output logic                     frame_start
);

    localparam int CW = (COL_DWELL > 1)     ? $clog2(COL_DWELL)     : 1;
    localparam int IW = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
    localparam int FW = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(COL_DWELL - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] COL_LAST   = IW'(TOTAL_COLUNES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0]            r_dwell;
    logic [IW-1:0]            r_col_idx;
    logic [FW-1:0]            r_frame;
    logic                     r_blink;
    logic [COLUNE_SIZE-1:0]   r_snap_row;
    logic [2:0]               r_snap_x;
    logic [2:0]               r_snap_y;
    logic                     r_snap_en;
    logic [TOTAL_COLUNES-1:0] r_col_out;
    logic [COLUNE_SIZE-1:0]   r_row_out;
    logic                     r_frame_start;

    logic [COLUNE_SIZE-1:0]   w_slices [TOTAL_COLUNES];
    logic                     w_new_dwell;
    logic [COLUNE_SIZE-1:0]   w_slice;
    logic [2:0]               w_x;
    logic [2:0]               w_y;
    logic                     w_en;
    logic [2:0]               w_y_idx;
    logic                     w_hit;
    logic [COLUNE_SIZE-1:0]   w_mask;
    logic [COLUNE_SIZE-1:0]   w_rows;
    logic                     w_blank;
    logic [TOTAL_COLUNES-1:0] w_onehot;

    // Column 0 occupies the most significant slice of the map.
    for (genvar k = 0; k < TOTAL_COLUNES; k++) begin : g_slice
        assign w_slices[k] = matriz_data[DATA_WIDTH-1-COLUNE_SIZE*k -: COLUNE_SIZE];
    end

    // On the first cycle of a dwell the snapshot is still being loaded, so use the live inputs.
    assign w_new_dwell = (r_dwell == '0);
    assign w_slice     = w_new_dwell ? w_slices[r_col_idx] : r_snap_row;
    assign w_x         = w_new_dwell ? x_coord_code        : r_snap_x;
    assign w_y         = w_new_dwell ? y_coord_code        : r_snap_y;
    assign w_en        = w_new_dwell ? cursor_enable       : r_snap_en;

    assign w_y_idx  = w_y - 3'd1;
    assign w_hit    = w_en && (32'(w_x) == 32'(r_col_idx) + 32'd1)
                      && (w_y != 3'd0) && (32'(w_y) <= COLUNE_SIZE);
    assign w_mask   = (w_hit && r_blink) ? (COLUNE_SIZE'(1) << w_y_idx) : '0;
    assign w_rows   = w_slice ^ w_mask;
    assign w_blank  = (r_dwell < BLANK_END);
    assign w_onehot = TOTAL_COLUNES'(1) << r_col_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell       <= '0;
            r_col_idx     <= '0;
            r_frame       <= '0;
            r_blink       <= 1'b0;
            r_snap_row    <= '1;
            r_snap_x      <= 3'd0;
            r_snap_y      <= 3'd0;
            r_snap_en     <= 1'b0;
            r_col_out     <= '0;
            r_row_out     <= '1;
            r_frame_start <= 1'b0;
        end else begin
            if (r_dwell == DWELL_LAST) begin
                r_dwell <= '0;
                if (r_col_idx == COL_LAST) begin
                    r_col_idx <= '0;
                    if (r_frame == FRAME_LAST) begin
                        r_frame <= '0;
                        r_blink <= ~r_blink;
                    end else begin
                        r_frame <= r_frame + 1'b1;
                    end
                end else begin
                    r_col_idx <= r_col_idx + 1'b1;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end

            if (w_new_dwell) begin
                r_snap_row <= w_slices[r_col_idx];
                r_snap_x   <= x_coord_code;
                r_snap_y   <= y_coord_code;
                r_snap_en  <= cursor_enable;
            end

            r_col_out     <= w_blank ? '0 : w_onehot;
            r_row_out     <= w_blank ? '1 : w_rows;
            r_frame_start <= (r_col_idx == '0) && (r_dwell == BLANK_END);
        end
    end

    assign matrix_col  = r_col_out;
    assign matrix_row  = r_row_out;
    assign frame_start = r_frame_start;

endmodule
